// File: rtl/sync_tx.sv
// sync_tx: frame serializer sending a sync word then a payload, MSB first, CLKDIV cycles per bit.
// Define SYNC_TX_MANCHESTER_EN for Manchester line coding; the default build is NRZ.
module sync_tx #(
  parameter int NDATA    = 128,
  parameter int NPAYLOAD = 64,
  parameter int CLKDIV   = 4,
  parameter int GAP      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NDATA-1:0]    sync_word,
  input  logic [NPAYLOAD-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                tx_out,
  output logic                tx_en,
  output logic                busy,
  output logic                done
);

  localparam int MAXN = (NDATA > NPAYLOAD) ? NDATA : NPAYLOAD;
  localparam int CW   = $clog2(CLKDIV) + 1;
  localparam int BW   = $clog2(MAXN) + 1;
  localparam int GW   = $clog2(GAP + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_GAP} state_t;

  state_t                state, nxt_state;
  logic [CW-1:0]         cyc, nxt_cyc;
  logic [BW-1:0]         bitc, nxt_bit;
  logic [GW-1:0]         gapc, nxt_gap;
  logic [NDATA-1:0]      sreg, nxt_sreg;
  logic [NPAYLOAD-1:0]   preg, nxt_preg;
  logic                  nxt_tx_out, nxt_tx_en, nxt_done;
  logic                  last_cyc, half, bitv;

  assign din_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign last_cyc  = (cyc == CW'(CLKDIV - 1));

  always_comb begin
    nxt_state = state;
    nxt_cyc   = cyc;
    nxt_bit   = bitc;
    nxt_gap   = gapc;
    nxt_sreg  = sreg;
    nxt_preg  = preg;
    nxt_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din_valid && din_ready) begin
          nxt_state = ST_SYNC;
          nxt_cyc   = '0;
          nxt_bit   = '0;
          nxt_sreg  = sync_word;
          nxt_preg  = din;
        end
      end
      ST_SYNC: begin
        if (last_cyc) begin
          nxt_cyc = '0;
          if (bitc == BW'(NDATA - 1)) begin
            nxt_state = ST_PAYLOAD;
            nxt_bit   = '0;
          end else begin
            nxt_bit  = bitc + 1'b1;
            nxt_sreg = sreg << 1;
          end
        end else begin
          nxt_cyc = cyc + 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (last_cyc) begin
          nxt_cyc = '0;
          if (bitc == BW'(NPAYLOAD - 1)) begin
            nxt_bit = '0;
            nxt_gap = '0;
            if (GAP > 0) begin
              nxt_state = ST_GAP;
            end else begin
              nxt_state = ST_IDLE;
              nxt_done  = 1'b1;
            end
          end else begin
            nxt_bit  = bitc + 1'b1;
            nxt_preg = preg << 1;
          end
        end else begin
          nxt_cyc = cyc + 1'b1;
        end
      end
      ST_GAP: begin
        if (last_cyc) begin
          nxt_cyc = '0;
          if (gapc == GW'(GAP - 1)) begin
            nxt_state = ST_IDLE;
            nxt_gap   = '0;
            nxt_done  = 1'b1;
          end else begin
            nxt_gap = gapc + 1'b1;
          end
        end else begin
          nxt_cyc = cyc + 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Line outputs are derived from the next-state values so the registered
    // tx_out/tx_en line up with the state they describe, starting right after acceptance.
    nxt_tx_en = (nxt_state == ST_SYNC) || (nxt_state == ST_PAYLOAD);
    bitv      = 1'b0;
    if (nxt_state == ST_SYNC)
      bitv = nxt_sreg[NDATA-1];
    else if (nxt_state == ST_PAYLOAD)
      bitv = nxt_preg[NPAYLOAD-1];
`ifdef SYNC_TX_MANCHESTER_EN
    half = (nxt_cyc >= CW'(CLKDIV / 2));
`else
    half = 1'b0;
`endif
    nxt_tx_out = nxt_tx_en & (bitv ^ half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cyc    <= '0;
      bitc   <= '0;
      gapc   <= '0;
      sreg   <= '0;
      preg   <= '0;
      tx_out <= 1'b0;
      tx_en  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nxt_state;
      cyc    <= nxt_cyc;
      bitc   <= nxt_bit;
      gapc   <= nxt_gap;
      sreg   <= nxt_sreg;
      preg   <= nxt_preg;
      tx_out <= nxt_tx_out;
      tx_en  <= nxt_tx_en;
      done   <= nxt_done;
    end
  end

endmodule

// File: tb/tb_sync_tx.sv
// tb_sync_tx: directed and randomized frames for sync_tx, checked against a per-cycle line model.
// Honours SYNC_TX_MANCHESTER_EN for the expected line coding.
module tb_sync_tx;

  localparam int NDATA    = 8;
  localparam int NPAYLOAD = 8;
  localparam int CLKDIV   = 2;
  localparam int GAP      = 2;
  localparam int NB       = NDATA + NPAYLOAD;
  localparam int TXC      = NB * CLKDIV;
  localparam int GC       = GAP * CLKDIV;

  logic                clk = 1'b0;
  logic                rst;
  logic [NDATA-1:0]    sync_word;
  logic [NPAYLOAD-1:0] din;
  logic                din_valid;
  logic                din_ready, tx_out, tx_en, busy, done;

  int checks   = 0;
  int failures = 0;

  sync_tx #(
    .NDATA   (NDATA),
    .NPAYLOAD(NPAYLOAD),
    .CLKDIV  (CLKDIV),
    .GAP     (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_word(sync_word),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .tx_out   (tx_out),
    .tx_en    (tx_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line value during transmit cycle j (1-based) of a frame carrying {sync, payload}.
  function automatic logic exp_line(input logic [NB-1:0] bits, input int j);
    int   b;
    logic v;
    b = (j - 1) / CLKDIV;
    v = bits[NB-1-b];
`ifdef SYNC_TX_MANCHESTER_EN
    if (((j - 1) % CLKDIV) >= CLKDIV / 2) v = ~v;
`endif
    return v;
  endfunction

  task automatic idle_checks(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({nm, ":idle_tx_en"}, tx_en, 1'b0);
      chk({nm, ":idle_tx_out"}, tx_out, 1'b0);
      chk({nm, ":idle_busy"}, busy, 1'b0);
      chk({nm, ":idle_done"}, done, 1'b0);
      chk({nm, ":idle_ready"}, din_ready, 1'b1);
    end
  endtask

  // Entered in an IDLE cycle; leaves in the done cycle (or after an abort + idle run).
  task automatic run_frame(input logic [NDATA-1:0] sw, input logic [NPAYLOAD-1:0] d,
                           input bit hold, input int poke_at, input int abort_at,
                           input string nm);
    logic [NB-1:0] bits;
    bits      = {sw, d};
    sync_word = sw;
    din       = d;
    din_valid = 1'b1;
    chk({nm, ":ready_pre"}, din_ready, 1'b1);
    step();
    for (int j = 1; j <= TXC + GC + 1; j++) begin
      if (j <= TXC + GC) begin
        sync_word = NDATA'($urandom);
        din       = NPAYLOAD'($urandom);
      end
      if (j == poke_at) begin
        din_valid = 1'b1;
        din       = '1;
      end else if (!hold) begin
        din_valid = 1'b0;
      end
      if (j <= TXC) begin
        chk({nm, ":line"}, tx_out, exp_line(bits, j));
        chk({nm, ":tx_en"}, tx_en, 1'b1);
        chk({nm, ":busy"}, busy, 1'b1);
        chk({nm, ":ready"}, din_ready, 1'b0);
        chk({nm, ":done"}, done, 1'b0);
      end else if (j <= TXC + GC) begin
        chk({nm, ":gap_line"}, tx_out, 1'b0);
        chk({nm, ":gap_tx_en"}, tx_en, 1'b0);
        chk({nm, ":gap_busy"}, busy, 1'b1);
        chk({nm, ":gap_ready"}, din_ready, 1'b0);
        chk({nm, ":gap_done"}, done, 1'b0);
      end else begin
        chk({nm, ":done_pulse"}, done, 1'b1);
        chk({nm, ":done_busy"}, busy, 1'b0);
        chk({nm, ":done_ready"}, din_ready, 1'b1);
        chk({nm, ":done_tx_en"}, tx_en, 1'b0);
        chk({nm, ":done_line"}, tx_out, 1'b0);
      end
      if (j == abort_at) begin
        rst       = 1'b1;
        din_valid = 1'b0;
        step();
        rst = 1'b0;
        chk({nm, ":abort_tx_out"}, tx_out, 1'b0);
        chk({nm, ":abort_tx_en"}, tx_en, 1'b0);
        chk({nm, ":abort_busy"}, busy, 1'b0);
        chk({nm, ":abort_done"}, done, 1'b0);
        chk({nm, ":abort_ready"}, din_ready, 1'b1);
        idle_checks({nm, ":post"}, GC + 3);
        return;
      end
      if (j <= TXC + GC) step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    sync_word = '0;
    din       = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_tx_out", tx_out, 1'b0);
      chk("reset_tx_en", tx_en, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
    end
    rst = 1'b0;
    chk("reset_ready", din_ready, 1'b1);
    idle_checks("reset_release", 2);

    run_frame(8'hA5, 8'h3C, 1'b0, 10, 0, "frame_a5");
    idle_checks("after_a5", 4);

    run_frame(NDATA'($urandom), NPAYLOAD'($urandom), 1'b1, 0, 0, "b2b_first");
    run_frame(NDATA'($urandom), NPAYLOAD'($urandom), 1'b0, 0, 0, "b2b_second");
    idle_checks("after_b2b", 2);

    run_frame(NDATA'($urandom), NPAYLOAD'($urandom), 1'b0, 0, 12, "abort");
    run_frame(8'h5A, 8'hC3, 1'b0, 0, 0, "post_abort");
    idle_checks("after_post_abort", 2);

    run_frame(8'h80, NPAYLOAD'($urandom), 1'b0, 0, 0, "sync_80");
    idle_checks("after_80", 1);

    rst       = 1'b1;
    din_valid = 1'b1;
    sync_word = 8'hA5;
    din       = 8'h3C;
    step();
    chk("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_tx_en", tx_en, 1'b0);
    rst       = 1'b0;
    din_valid = 1'b0;
    idle_checks("rst_prio", 2);

    for (int n = 0; n < 4; n++) begin
      run_frame(NDATA'($urandom), NPAYLOAD'($urandom), 1'b0,
                int'($urandom_range(1, TXC + GC)), 0, "random");
      idle_checks("random_after", 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_tx.md
SYNC_TX -- requirements
Module: sync_tx

Interface
REQ-001 Parameter NDATA, default 128: sync word length in bits; this is the pattern width the receive-side correlator matches against.
REQ-002 Parameter NPAYLOAD, default 64: payload bits per frame.
REQ-003 Parameter CLKDIV, default 4: clock cycles per transmitted bit, at least 1 (at least 2 and even when SYNC_TX_MANCHESTER_EN is defined).
REQ-004 Parameter GAP, default 2: idle bit periods after each frame.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 sync_word  input  NDATA  sync pattern, sampled at frame acceptance.
REQ-008 din  input  NPAYLOAD  payload, sampled at frame acceptance.
REQ-009 din_valid  input  1  payload offered.
REQ-010 din_ready  output  1  block can accept a frame.
REQ-011 tx_out  output  1  serial line data, registered.
REQ-012 tx_en  output  1  high while frame bits are on tx_out, registered.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 FSM states: IDLE, SYNC, PAYLOAD, GAP; transitions IDLE->SYNC->PAYLOAD->GAP->IDLE only.
REQ-016 IDLE: din_ready=1, tx_en=0, tx_out=0.
REQ-017 Acceptance occurs on a clock edge where state is IDLE and din_valid&din_ready; sync_word and din latch into internal shift registers on that edge.
REQ-018 Latency: first sync bit appears on tx_out with tx_en=1 in the cycle immediately after the acceptance edge.
REQ-019 SYNC: sync_word is sent MSB first, NDATA bits, each held CLKDIV cycles.
REQ-020 PAYLOAD: din is sent MSB first, NPAYLOAD bits, each held CLKDIV cycles, contiguous with SYNC and with no gap cycle.
REQ-021 tx_en is high for exactly (NDATA+NPAYLOAD)*CLKDIV consecutive cycles per frame.
REQ-022 GAP: tx_en=0 and tx_out=0 for GAP*CLKDIV cycles, then the FSM returns to IDLE; GAP=0 skips the state.
REQ-023 done is high for exactly the first IDLE cycle after GAP; din_ready is also high in that cycle, so a frame can be accepted there (back-to-back).
REQ-024 din_ready=0 from the cycle after acceptance until return to IDLE; din_valid outside IDLE is ignored and has no effect on outputs.
REQ-025 Changes to sync_word or din after acceptance do not alter the frame in flight.
REQ-026 Counters: cycle counter width $clog2(CLKDIV)+1; bit counter width $clog2(max(NDATA,NPAYLOAD))+1; no wrap occurs within a state.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, counters=0, shift registers=0, tx_out=0, tx_en=0, busy=0, done=0, and din_ready=1 from the next cycle.
REQ-028 Reset asserted mid-frame aborts the frame immediately, with no done pulse and no GAP.
REQ-029 Reset takes priority over a simultaneous acceptance.

Configuration
REQ-030 Macro SYNC_TX_MANCHESTER_EN defined: each bit period is split into halves of CLKDIV/2 cycles; first half tx_out=bit, second half tx_out=~bit; tx_en timing is unchanged.
REQ-031 Macro SYNC_TX_MANCHESTER_EN undefined: NRZ; tx_out holds the bit value for all CLKDIV cycles.

Verification (NDATA=8, NPAYLOAD=8, CLKDIV=2, GAP=2)
REQ-032 Reset: rst high for 3 cycles -> tx_out=0, tx_en=0, busy=0, done=0; din_ready=1 after release.
REQ-033 Frame: sync_word=8'hA5, din=8'h3C accepted at edge k -> tx_out=1010010100111100 with each bit held 2 cycles over cycles k+1..k+32, tx_en high throughout, tx_out=0 for cycles k+33..k+36, done=1 at cycle k+37.
REQ-034 Busy ignore: second din_valid pulse with din=8'hFF at cycle k+10 -> frame unchanged, no second frame started.
REQ-035 Back-to-back: din_valid held high -> second acceptance at the done cycle k+37; second frame's first bit at k+38.
REQ-036 Abort: rst at cycle k+12 -> all outputs reset the next cycle, no done pulse, din_ready=1, and a new frame is accepted normally.
REQ-037 Manchester (macro defined): sync_word=8'h80 -> tx_out pairs 1,0 then 0,1 repeated 7 times.
